axi_gran_ax_sequencer: RTL and testbench
========================================

Name: axi_gran_ax_sequencer

Overview:
Sequences one AXI AW or AR channel into the granular burst-splitter datapath. For each incoming burst it allocates a beat counter in the counter bank through an alloc req/gnt port. It then emits the burst as a series of sub-bursts of at most (len_limit_i+1) beats, advancing the address for INCR bursts. It sits between the slave-side AX channel and the master-side AX channel; one instance is used for reads and one for writes.

Parameters:
AddrWidth, 64, address width in bits
IdWidth, 4, AXI ID width in bits

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
len_limit_i  in  8  maximum sub-burst length, encoded as beats-1; sampled on AX acceptance
ax_id_i  in  IdWidth  incoming burst ID
ax_addr_i  in  AddrWidth  incoming start address
ax_len_i  in  8  incoming burst length (beats-1)
ax_size_i  in  3  incoming beat size (log2 bytes)
ax_burst_i  in  2  burst type (FIXED=0, INCR=1, WRAP=2)
ax_valid_i  in  1  incoming burst valid
ax_ready_o  out  1  incoming burst ready
alloc_id_o  out  IdWidth  counter-bank allocation ID
alloc_len_o  out  8  counter-bank allocation length (original ax_len)
alloc_req_o  out  1  counter-bank allocation request
alloc_gnt_i  in  1  counter-bank allocation grant
sub_id_o  out  IdWidth  sub-burst ID (equal to the captured ID)
sub_addr_o  out  AddrWidth  sub-burst start address
sub_len_o  out  8  sub-burst length (beats-1)
sub_size_o  out  3  sub-burst size (equal to the captured size)
sub_burst_o  out  2  sub-burst type (equal to the captured type)
sub_last_o  out  1  high on the final sub-burst of the parent burst
sub_valid_o  out  1  sub-burst valid
sub_ready_i  in  1  sub-burst ready
busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: rst_i sampled on the clk_i edge. Next cycle: state=IDLE, ax_ready_o=1, alloc_req_o=0, sub_valid_o=0, busy_o=0, all captured registers cleared to 0.
- Reset mid-operation: the current burst is abandoned. No further alloc_req or sub_valid is raised. A counter already granted is not released by this block; the counter bank is reset alongside it.
- FSM has three states: IDLE, ALLOC, SPLIT.
- IDLE:
  - ax_ready_o=1.
  - On ax_valid_i&ax_ready_o, capture id, addr, len, size, burst and len_limit_i.
  - Load rem (9 bits) = ax_len_i+1. Go to ALLOC.
- ALLOC:
  - alloc_req_o=1, alloc_id_o=captured id, alloc_len_o=captured len.
  - Holds until alloc_gnt_i, then go to SPLIT.
  - alloc_req_o never drops before the grant; alloc_* outputs stay stable while requested.
- SPLIT, output values:
  - sub_valid_o=1.
  - For INCR: sub_len_o = min(rem-1, limit).
  - For FIXED and WRAP: no splitting; sub_len_o = captured len and sub_last_o=1.
  - For INCR: sub_last_o = (rem-1 <= limit).
- SPLIT, on sub_valid_o&sub_ready_i:
  - rem -= sub_len_o+1.
  - For INCR only: addr += (sub_len_o+1) << size, computed modulo 2^AddrWidth. FIXED keeps the address.
  - If sub_last_o, go to IDLE; else stay in SPLIT.
- Handshake rules: all sub_* outputs are driven from registers and stay stable while sub_valid_o=1 and sub_ready_i=0. sub_valid_o never drops without a handshake.
- Latency: AX accepted in cycle 0 → alloc_req_o in cycle 1. With alloc_gnt_i in cycle 1, the first sub_valid_o is in cycle 2. Each subsequent sub-burst follows one cycle after the previous handshake.
- Throughput: one parent burst in flight. ax_ready_o=0 in ALLOC and SPLIT. The next burst is accepted at the earliest in the cycle after the last sub-burst handshake.
- Width rules:
  - rem is 9 bits so that len=255 gives rem=256.
  - Number of sub-bursts for INCR = ceil((len+1)/(limit+1)).
  - len_limit_i=255 disables splitting.
  - len_limit_i changes after acceptance do not affect the burst in flight.
- Simultaneous events: rst_i wins over any handshake in the same cycle.
- busy_o = (state != IDLE).

Test Plan:
- Reset then idle → ax_ready_o=1, alloc_req_o=0, sub_valid_o=0, busy_o=0.
- INCR addr=0x1000, len=7, size=3, limit=1, alloc and sub ready always high → alloc_req in cycle 1 with alloc_len=7; 4 sub-bursts at 0x1000, 0x1010, 0x1020, 0x1030, each len=1; last only on the 4th; ax_ready back high the cycle after.
- INCR len=4, limit=2 → sub-bursts with len 2 then 1 at addr A and A+(3<<size); last on the 2nd.
- INCR len=255, limit=255 and FIXED len=15, limit=0 → a single sub-burst each, len 255 and 15 respectively, last=1; FIXED keeps its address.
- alloc_gnt_i held low 5 cycles, then sub_ready_i toggled randomly → alloc_req and sub_* stay stable until each handshake; no sub_valid before the grant; change len_limit_i mid-burst → split count unchanged.
- Assert rst_i while in SPLIT after the 2nd of 4 sub-bursts → next cycle sub_valid_o=0, state IDLE, ax_ready_o=1; the next burst is processed normally.

Source files
------------

// File: rtl/axi_gran_ax_sequencer.sv
// axi_gran_ax_sequencer: allocates a beat counter per AX burst, then emits it as
// sub-bursts of at most len_limit+1 beats, advancing the address for INCR bursts.
module axi_gran_ax_sequencer #(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           len_limit_i,
    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    output logic [IdWidth-1:0]   alloc_id_o,
    output logic [7:0]           alloc_len_o,
    output logic                 alloc_req_o,
    input  logic                 alloc_gnt_i,
    output logic [IdWidth-1:0]   sub_id_o,
    output logic [AddrWidth-1:0] sub_addr_o,
    output logic [7:0]           sub_len_o,
    output logic [2:0]           sub_size_o,
    output logic [1:0]           sub_burst_o,
    output logic                 sub_last_o,
    output logic                 sub_valid_o,
    input  logic                 sub_ready_i,
    output logic                 busy_o
);
    typedef enum logic [1:0] {IDLE, ALLOC, SPLIT} state_t;
    state_t                 state;
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [7:0]             len, limit;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [8:0]             rem, rem_m1, beats;
    logic                   incr, fits;
    assign incr        = burst == 2'd1;
    assign rem_m1      = rem - 9'd1;
    assign fits        = rem_m1 <= {1'b0, limit};
    // FIXED and WRAP bursts are never split
    assign sub_len_o   = !incr ? len : fits ? rem_m1[7:0] : limit;
    assign sub_last_o  = !incr || fits;
    assign beats       = {1'b0, sub_len_o} + 9'd1;
    assign ax_ready_o  = state == IDLE;
    assign alloc_req_o = state == ALLOC;
    assign sub_valid_o = state == SPLIT;
    assign busy_o      = state != IDLE;
    assign alloc_id_o  = id;
    assign alloc_len_o = len;
    assign sub_id_o    = id;
    assign sub_addr_o  = addr;
    assign sub_size_o  = size;
    assign sub_burst_o = burst;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            id    <= '0;
            addr  <= '0;
            len   <= '0;
            limit <= '0;
            size  <= '0;
            burst <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: if (ax_valid_i) begin
                    id    <= ax_id_i;
                    addr  <= ax_addr_i;
                    len   <= ax_len_i;
                    size  <= ax_size_i;
                    burst <= ax_burst_i;
                    limit <= len_limit_i;
                    rem   <= {1'b0, ax_len_i} + 9'd1;
                    state <= ALLOC;
                end
                ALLOC: if (alloc_gnt_i) state <= SPLIT;
                SPLIT: if (sub_ready_i) begin
                    rem <= rem - beats;
                    if (incr) addr <= addr + (AddrWidth'(beats) << size);
                    if (sub_last_o) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_gran_ax_sequencer.sv
// tb_axi_gran_ax_sequencer: directed bursts with hand-computed sub-burst sequences.
module tb_axi_gran_ax_sequencer;
    logic        clk = 0, rst = 1;
    logic [7:0]  len_limit = 0;
    logic [3:0]  ax_id = 0;
    logic [63:0] ax_addr = 0;
    logic [7:0]  ax_len = 0;
    logic [2:0]  ax_size = 0;
    logic [1:0]  ax_burst = 0;
    logic        ax_valid = 0, ax_ready;
    logic [3:0]  alloc_id;
    logic [7:0]  alloc_len;
    logic        alloc_req, alloc_gnt = 0;
    logic [3:0]  sub_id;
    logic [63:0] sub_addr;
    logic [7:0]  sub_len;
    logic [2:0]  sub_size;
    logic [1:0]  sub_burst;
    logic        sub_last, sub_valid, sub_ready = 0, busy;
    int errors = 0, checks = 0;

    axi_gran_ax_sequencer dut (
        .clk_i(clk), .rst_i(rst), .len_limit_i(len_limit),
        .ax_id_i(ax_id), .ax_addr_i(ax_addr), .ax_len_i(ax_len), .ax_size_i(ax_size),
        .ax_burst_i(ax_burst), .ax_valid_i(ax_valid), .ax_ready_o(ax_ready),
        .alloc_id_o(alloc_id), .alloc_len_o(alloc_len), .alloc_req_o(alloc_req),
        .alloc_gnt_i(alloc_gnt), .sub_id_o(sub_id), .sub_addr_o(sub_addr),
        .sub_len_o(sub_len), .sub_size_o(sub_size), .sub_burst_o(sub_burst),
        .sub_last_o(sub_last), .sub_valid_o(sub_valid), .sub_ready_i(sub_ready),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_checks();
        check("ax_ready", 64'(ax_ready), 1);
        check("alloc_req", 64'(alloc_req), 0);
        check("sub_valid", 64'(sub_valid), 0);
        check("busy", 64'(busy), 0);
    endtask

    // entered and left at a negedge; ll is the expected length of the last sub-burst
    task automatic run(input logic [3:0] id, input logic [1:0] bt, input logic [63:0] a,
                       input logic [7:0] l, input logic [2:0] sz, input logic [7:0] lim,
                       input int gw, input bit rr, input int n, input logic [7:0] lm,
                       input logic [7:0] ll, input logic [63:0] stride, input int stop);
        logic [63:0] ea;
        logic [7:0]  el;
        bit          hs;
        check("ax_ready_pre", 64'(ax_ready), 1);
        ax_id = id; ax_addr = a; ax_len = l; ax_size = sz; ax_burst = bt;
        len_limit = lim; ax_valid = 1;
        @(posedge clk);
        #1 ax_valid = 0; len_limit = ~lim;
        @(negedge clk);
        check("alloc_req", 64'(alloc_req), 1);
        check("alloc_len", 64'(alloc_len), 64'(l));
        check("alloc_id", 64'(alloc_id), 64'(id));
        check("ax_ready_busy", 64'(ax_ready), 0);
        check("busy", 64'(busy), 1);
        check("sub_valid_alloc", 64'(sub_valid), 0);
        for (int i = 0; i < gw; i++) begin
            @(negedge clk);
            check("alloc_req_hold", 64'(alloc_req), 1);
            check("alloc_len_hold", 64'(alloc_len), 64'(l));
            check("alloc_id_hold", 64'(alloc_id), 64'(id));
            check("sub_valid_nognt", 64'(sub_valid), 0);
        end
        alloc_gnt = 1;
        @(negedge clk);
        alloc_gnt = 0;
        for (int k = 0; k < stop; k++) begin
            ea = a + 64'(k) * stride;
            el = (k == n - 1) ? ll : lm;
            hs = 0;
            for (int t = 0; t < 40 && !hs; t++) begin
                sub_ready = (!rr || t >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                check("sub_valid", 64'(sub_valid), 1);
                check("sub_addr", sub_addr, ea);
                check("sub_len", 64'(sub_len), 64'(el));
                check("sub_last", 64'(sub_last), 64'(k == n - 1));
                check("sub_id", 64'(sub_id), 64'(id));
                check("sub_size", 64'(sub_size), 64'(sz));
                check("sub_burst", 64'(sub_burst), 64'(bt));
                check("alloc_req_split", 64'(alloc_req), 0);
                hs = sub_ready;
                @(negedge clk);
            end
        end
        sub_ready = 0;
        if (stop == n) idle_checks();
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        idle_checks();
        rst = 0;
        run(4'h3, 2'd1, 64'h1000, 8'd7,   3'd3, 8'd1,   0, 0, 4, 8'd1, 8'd1,   64'h10, 4);
        run(4'h5, 2'd1, 64'h2000, 8'd4,   3'd3, 8'd2,   0, 0, 2, 8'd2, 8'd1,   64'h18, 2);
        run(4'h6, 2'd1, 64'h3000, 8'd255, 3'd0, 8'd255, 0, 0, 1, 8'd0, 8'd255, 64'h0,  1);
        run(4'h7, 2'd0, 64'h4000, 8'd15,  3'd2, 8'd0,   0, 0, 1, 8'd0, 8'd15,  64'h0,  1);
        run(4'h8, 2'd2, 64'h5040, 8'd3,   3'd2, 8'd0,   0, 0, 1, 8'd0, 8'd3,   64'h0,  1);
        run(4'h9, 2'd1, 64'h6000, 8'd9,   3'd2, 8'd2,   5, 1, 4, 8'd2, 8'd0,   64'hC,  4);
        run(4'hA, 2'd1, 64'h7000, 8'd7,   3'd3, 8'd1,   0, 0, 4, 8'd1, 8'd1,   64'h10, 2);
        // reset wins over a handshake offered in the same cycle
        sub_ready = 1; rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0; sub_ready = 0;
        idle_checks();
        check("sub_addr_rst", sub_addr, 0);
        check("alloc_len_rst", 64'(alloc_len), 0);
        @(negedge clk);
        check("sub_valid_after_rst", 64'(sub_valid), 0);
        run(4'hB, 2'd1, 64'h1000, 8'd7,   3'd3, 8'd1,   0, 0, 4, 8'd1, 8'd1,   64'h10, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
